// File: rtl/mitchell_decoder_pipe.sv
// Pipelined multi-lane Mitchell antilogarithm decoder.
// Each lane turns a log-domain result {c, m} into the linear value
// floor(((2^K + m) << c) / 2^K), or the round-half-up version of it.
// Stage 1 registers the exact shifted value, and stage 2 applies the
// rounding add and the zero mask. Every lane shares one valid/ready handshake.
module mitchell_decoder_pipe #(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int K     = 5,
  parameter int LANES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*(LOG_N+K+1)-1:0] in_res,
  input  logic [LANES-1:0]           in_zero,
  input  logic                       in_round,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*2*N-1:0]       out_z
);

  localparam int LW = LOG_N + K + 1;
  localparam int PW = K + 2 * N;
  localparam int ZW = 2 * N;

  // Half of one output LSB, expressed in units of the exact product P.
  localparam logic [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (K - 1);

  // Exact product P = (2^K + m) << c. It always fits in PW bits because c <= 2N-1.
  function automatic logic [PW-1:0] lane_shift(input logic [LW-1:0] r);
    logic [LOG_N:0] c;
    logic [K-1:0]   m;
    c = r[LW-1:K];
    m = r[K-1:0];
    return {{(PW-K-1){1'b0}}, 1'b1, m} << c;
  endfunction

  // Optional half-LSB add, then drop the K fractional bits. With K <= N-1 the
  // rounding carry never spills past 2N bits, so no saturation is needed.
  function automatic logic [ZW-1:0] lane_round(input logic [PW-1:0] p,
                                               input logic          rnd,
                                               input logic          zero);
    logic [PW-1:0] sum;
    sum = p + (rnd ? HALF : {PW{1'b0}});
    if (zero) begin
      return {ZW{1'b0}};
    end
    return ZW'(sum >> K);
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [LANES*PW-1:0]   s1_p_q, s1_p_d;
  logic [LANES-1:0]      s1_zero_q, s1_zero_d;
  logic                  s1_round_q, s1_round_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [LANES*ZW-1:0]   out_z_q, out_z_d;
  logic                  s1_adv;
  logic                  s2_adv;

  // Pipeline advance conditions. Ready depends only on state and out_ready.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Stage 1 next state: capture the shifted products whenever a beat is accepted.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_zero_d  = s1_zero_q;
    s1_round_d = s1_round_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          s1_p_d[i*PW +: PW] = lane_shift(in_res[i*LW +: LW]);
        end
        s1_zero_d  = in_zero;
        s1_round_d = in_round;
      end
    end
  end

  // Stage 2 next state: round, mask, and hold the result while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_z_d    = out_z_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++) begin
          out_z_d[i*ZW +: ZW] = lane_round(s1_p_q[i*PW +: PW], s1_round_q, s1_zero_q[i]);
        end
      end
    end
  end

  // Pipeline registers. Reset discards any beats in flight and clears the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_zero_q  <= '0;
      s1_round_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_z_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_zero_q  <= s1_zero_d;
      s1_round_q <= s1_round_d;
      s2_valid_q <= s2_valid_d;
      out_z_q    <= out_z_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_mitchell_decoder_pipe.sv
// Directed bench for mitchell_decoder_pipe with N=8, K=5 and four lanes.
// Lane vectors are packed {lane3, lane2, lane1, lane0}.
// Every expected value below was worked out by hand from (2^K+m)*2^c / 2^K.
module tb_mitchell_decoder_pipe;

  localparam int N     = 8;
  localparam int LOG_N = 3;
  localparam int K     = 5;
  localparam int LANES = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_res;
  logic [3:0]  in_zero;
  logic        in_round;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_z;

  int errors = 0;
  int checks = 0;

  mitchell_decoder_pipe #(.N(N), .LOG_N(LOG_N), .K(K), .LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_res   (in_res),
    .in_zero  (in_zero),
    .in_round (in_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z)
  );

  // Free-running clock with rising edges at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that stops a run which never finishes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [8:0] mk(input int c, input int m);
    logic [3:0] cc;
    logic [4:0] mm;
    cc = c[3:0];
    mm = m[4:0];
    return {cc, mm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [35:0] res, input logic [3:0] zero,
                               input logic rnd, input logic valid);
    in_res   = res;
    in_zero  = zero;
    in_round = rnd;
    in_valid = valid;
  endtask

  // Sends one beat on an idle pipe with out_ready high and checks the two-cycle latency.
  task automatic runBeat(input string tag, input logic [35:0] res, input logic [3:0] zero,
                         input logic rnd, input logic [63:0] exp);
    applyStimulus(res, zero, rnd, 1'b1);
    checkOutput({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, " valid_t1"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, " valid_t2"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, " z"}, out_z, exp);
    @(posedge clk); #1;
    checkOutput({tag, " drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(36'd0, 4'd0, 1'b0, 1'b0);

    // Reset state, then release reset and accept a beat on the very next edge.
    @(posedge clk); #1;
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset out_z", out_z, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle in_ready", {63'd0, in_ready}, 64'd1);

    // Mixed lanes in truncate mode: c=3,m=16 -> 12; c=0,m=31 -> 1; c=15,m=31 -> FC00; c=4,m=31 -> 31
    runBeat("mix_trunc", {mk(4,31), mk(15,31), mk(0,31), mk(3,16)}, 4'b0000, 1'b0,
            {16'd31, 16'hFC00, 16'd1, 16'd12});
    // The same lanes in round mode: 63/32 -> 2, 1008/32 -> 32, and c >= K is unchanged
    runBeat("mix_round", {mk(4,31), mk(15,31), mk(0,31), mk(3,16)}, 4'b0000, 1'b1,
            {16'd32, 16'hFC00, 16'd2, 16'd12});
    // Round mode: c=1,m=1 -> 2 (66/32); c=15,m=0 -> 8000; c=0,m=0 -> 1; c=7,m=5 -> 148
    runBeat("edge_round", {mk(7,5), mk(0,0), mk(15,0), mk(1,1)}, 4'b0000, 1'b1,
            {16'd148, 16'd1, 16'h8000, 16'd2});
    runBeat("max_trunc", {mk(15,31), mk(15,0), mk(15,31), mk(15,0)}, 4'b0000, 1'b0,
            {16'hFC00, 16'h8000, 16'hFC00, 16'h8000});
    // Zero bypass on lanes 0 and 2, in both modes.
    runBeat("zero_trunc", {4{mk(3,16)}}, 4'b0101, 1'b0, {16'd12, 16'd0, 16'd12, 16'd0});
    runBeat("zero_round", {4{mk(3,16)}}, 4'b0101, 1'b1, {16'd12, 16'd0, 16'd12, 16'd0});
    runBeat("zero_all", {4{mk(15,31)}}, 4'b1111, 1'b1, 64'd0);

    // Backpressure: four back-to-back beats with c=0..3 and out_ready held low.
    out_ready = 1'b0;
    applyStimulus({4{mk(0,0)}}, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus({4{mk(1,0)}}, 4'd0, 1'b0, 1'b1);
    checkOutput("bp in_ready_b", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    applyStimulus({4{mk(2,0)}}, 4'd0, 1'b0, 1'b1);
    checkOutput("bp out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp in_ready_full", {63'd0, in_ready}, 64'd0);
    checkOutput("bp z_first", out_z, {4{16'd1}});
    @(posedge clk); #1;
    checkOutput("bp stall1 z", out_z, {4{16'd1}});
    checkOutput("bp stall1 valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp stall1 ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("bp stall2 z", out_z, {4{16'd1}});
    out_ready = 1'b1;
    #1;
    checkOutput("bp release ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    checkOutput("bp z2", out_z, {4{16'd2}});
    applyStimulus({4{mk(3,0)}}, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp z4", out_z, {4{16'd4}});
    @(posedge clk); #1;
    checkOutput("bp z8", out_z, {4{16'd8}});
    checkOutput("bp z8 valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    checkOutput("bp empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of a cycle, with two beats in flight.
    applyStimulus({4{mk(5,0)}}, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus({4{mk(6,0)}}, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_rst z", out_z, {4{16'd32}});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_rst z", out_z, 64'd0);
    @(posedge clk); #1;
    checkOutput("in_rst valid", {63'd0, out_valid}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("post_rst ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    checkOutput("no_stale valid", {63'd0, out_valid}, 64'd0);
    checkOutput("no_stale z", out_z, 64'd0);
    runBeat("after_rst", {mk(1,0), mk(0,0), mk(2,31), mk(2,0)}, 4'd0, 1'b0,
            {16'd2, 16'd1, 16'd7, 16'd4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
